deserializer: RTL
=================

Name: deserializer

Overview:
Receive-side counterpart of the team's serializer. Collects an MSB-first serial burst framed by a valid strobe and presents it as one parallel word. The word carries a length code in the same data_mod encoding the serializer accepts. Sits at the far end of the serial link, feeding the parallel datapath; no backpressure.

Parameters:
DATA_BUS_WIDTH, 16, parallel word width in bits; must be a power of two, at least 4.
DATA_MOD_WIDTH, 4, width of the length code; must equal $clog2(DATA_BUS_WIDTH).

Ports:
clk_i  input  1  clock; all logic on posedge.
srst_i  input  1  synchronous reset, active-low (0 = reset).
ser_data_i  input  1  serial data bit, MSB of the word first.
ser_data_val_i  input  1  qualifies ser_data_i; a burst is a contiguous run of high cycles.
deser_data_o  output  DATA_BUS_WIDTH  received word, left-aligned; unreceived LSBs are 0.
deser_data_mod_o  output  DATA_MOD_WIDTH  bits received; 0 means a full DATA_BUS_WIDTH.
deser_data_val_o  output  1  one-cycle pulse; deser_data_o and deser_data_mod_o are valid.
drop_o  output  1  one-cycle pulse; a 1- or 2-bit burst was discarded.
busy_o  output  1  high while a burst is being accumulated.

Behaviour:
- Reset (srst_i == 0, sampled on posedge): state goes to IDLE, bit counter goes to 0, shift register is cleared. All outputs are 0 in the following cycle. A partial word in flight is discarded with no valid and no drop.
- Bit counter is $clog2(DATA_BUS_WIDTH+1) bits wide and counts 0..DATA_BUS_WIDTH. Shift register is DATA_BUS_WIDTH bits; each accepted bit enters at the LSB, so the first bit ends up highest.
- States:
  - IDLE:
    - busy_o = 0.
    - ser_data_val_i = 1: shift the bit in, count = 1, go to RECV.
  - RECV:
    - busy_o = 1.
    - ser_data_val_i = 1 and count < W-1: shift, count+1, stay.
    - ser_data_val_i = 1 and count == W-1 (the W-th bit): shift and complete a full word.
      - Next cycle: deser_data_val_o = 1, deser_data_o = the word, deser_data_mod_o = 0.
      - count goes to 0 and state returns to IDLE.
    - ser_data_val_i = 0 and count >= 3 (count is n): complete a short word.
      - Next cycle: deser_data_val_o = 1, deser_data_o = shift register << (W-n), deser_data_mod_o = n.
      - Go to IDLE.
    - ser_data_val_i = 0 and count in {1,2}: drop_o = 1 next cycle, no valid pulse, go to IDLE.
- Latency:
  - Full word: valid pulse in the cycle after the W-th bit is sampled.
  - Short word: valid pulse in the cycle after ser_data_val_i is first sampled low, i.e. two cycles after the last bit.
- Continuous valid longer than W cycles: split into consecutive full words with no lost bits. The bit sampled while deser_data_val_o is pulsing is the first bit of the next word. Back-to-back valid pulses every W cycles are legal.
- deser_data_o and deser_data_mod_o are registered. They hold their value until the next completion and are meaningful only while deser_data_val_o = 1. They reset to 0.
- ser_data_i is ignored when ser_data_val_i = 0.
- Round-trip property: serializer input (data_i, data_mod_i) gives the same data_mod value here. Output data equals data_i with the low W-n bits forced to 0 (n = data_mod_i, 0 means W).

Decomposition:
- Shared package serdes_pkg:
  - state enum type (IDLE_S, RECV_S);
  - MIN_BURST_LEN = 3;
  - function computing the data_mod code from a bit count (W maps to 0).
- The serializer is refactored to take MIN_BURST_LEN from the same package.
- Natural sub-module: deser_shift_reg. Holds the W-bit shift register and counter, with shift-enable and clear inputs and a count output. The FSM, alignment shift and output registers stay in the top.

Test Plan:
- Full word: 16 valid cycles with bits of 0xA5C3 MSB-first -> next cycle val=1, data=0xA5C3, mod=0, busy back to 0.
- Short word: 5 valid cycles with bits 1,0,1,1,0, then valid low -> two cycles after the last bit, val=1, data=0xB000, mod=5.
- Short bursts: 2-bit burst 1,1 -> drop_o=1 for one cycle, no valid. Then a 1-bit burst -> drop_o again.
- Continuous stream: 32 contiguous valid cycles carrying 0x1234 then 0xFFFF -> val pulses 16 cycles apart, data 0x1234 then 0xFFFF, both mod=0.
- Reset mid-burst: 7 bits, then srst_i=0 for one cycle, then a full 0x8001 burst -> no output for the aborted burst, then data=0x8001, mod=0.
- Loopback: serializer wired to deserializer, 1000 random (data_i, data_mod_i in {0,3..15}) -> every output matches the round-trip property.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared definitions for the serial link endpoints (serializer and deserializer).
//   state_e              : receive FSM states.
//   MIN_BURST_LEN        : shortest burst that forms a word; shorter ones are dropped.
//   data_mod_from_count  : converts a received bit count into the data_mod length code,
//                          where a full bus width is encoded as 0.
package serdes_pkg;

  typedef enum logic {
    IDLE_S = 1'b0,
    RECV_S = 1'b1
  } state_e;

  localparam int unsigned MIN_BURST_LEN = 3;

  function automatic int unsigned data_mod_from_count(input int unsigned count,
                                                      input int unsigned bus_width);
    return (count >= bus_width) ? 0 : count;
  endfunction

endpackage

// File: rtl/deser_shift_reg.sv
// Bit accumulator for the deserializer.
//   clk_i      : clock, posedge.
//   srst_i     : synchronous reset, active-low; clears register and counter.
//   shift_en_i : shift bit_i in at the LSB and (unless clear_i) bump the counter.
//   bit_i      : serial bit to shift in.
//   clear_i    : returns the counter to 0; the register contents are left alone.
//   data_o     : shift register contents, first bit received sits highest.
//   cnt_o      : number of bits accumulated in the current word.
module deser_shift_reg #(
  parameter int unsigned W    = 16,
  parameter int unsigned CNT_W = $clog2(W + 1)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             shift_en_i,
  input  logic             bit_i,
  input  logic             clear_i,
  output logic [W-1:0]     data_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [W-1:0]     sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Stale high bits from an earlier word need no clearing: the alignment
  // shift in the top discards everything above the current count.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (shift_en_i) begin
      sr_d  = {sr_q[W-2:0], bit_i};
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Clear wins over the increment so the W-th bit can be shifted in while
    // the counter wraps to 0 for the next word.
    if (clear_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign data_o = sr_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel receiver. Collects an MSB-first burst framed by
// ser_data_val_i and presents it as one left-aligned parallel word plus a
// data_mod length code (0 = full width). No backpressure: the output is a
// one-cycle deser_data_val_o pulse and the consumer must take it then.
//   clk_i            : clock, posedge.
//   srst_i           : synchronous reset, active-low.
//   ser_data_i       : serial data bit, MSB first.
//   ser_data_val_i   : qualifies ser_data_i; a burst is a contiguous run of highs.
//   deser_data_o     : received word, left-aligned, unreceived LSBs are 0.
//   deser_data_mod_o : bits received, 0 means a full word.
//   deser_data_val_o : one-cycle pulse marking deser_data_o/deser_data_mod_o valid.
//   drop_o           : one-cycle pulse when a too-short burst was discarded.
//   busy_o           : high while a burst is being accumulated.
module deserializer
  import serdes_pkg::*;
#(
  parameter int unsigned DATA_BUS_WIDTH = 16,
  parameter int unsigned DATA_MOD_WIDTH = 4
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic                      ser_data_i,
  input  logic                      ser_data_val_i,
  output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
  output logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o,
  output logic                      deser_data_val_o,
  output logic                      drop_o,
  output logic                      busy_o
);

  localparam int unsigned W     = DATA_BUS_WIDTH;
  localparam int unsigned CNT_W = $clog2(DATA_BUS_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BUS_WIDTH - 1);
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_BURST_LEN);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_BUS_WIDTH);

  state_e state_q, state_d;

  logic [W-1:0]     sr;
  logic [CNT_W-1:0] cnt;

  logic shift_en;
  logic cnt_clear;
  logic done_full;
  logic done_short;
  logic done_drop;
  logic busy;

  logic [W-1:0]              data_q, data_d;
  logic [DATA_MOD_WIDTH-1:0] mod_q, mod_d;
  logic                      val_q, drop_q;
  logic [CNT_W-1:0]          align_shamt;

  deser_shift_reg #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_shift_reg (
    .clk_i      (clk_i),
    .srst_i     (srst_i),
    .shift_en_i (shift_en),
    .bit_i      (ser_data_i),
    .clear_i    (cnt_clear),
    .data_o     (sr),
    .cnt_o      (cnt)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      state_q <= IDLE_S;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_S: begin
        if (ser_data_val_i) state_d = RECV_S;
      end
      RECV_S: begin
        if (!ser_data_val_i || (cnt == LAST_CNT)) state_d = IDLE_S;
      end
      default: state_d = IDLE_S;
    endcase
  end

  // FSM outputs. Every qualified bit is shifted in regardless of state, so
  // the bit arriving while a full word's valid pulses starts the next word.
  always_comb begin
    shift_en   = ser_data_val_i;
    cnt_clear  = 1'b0;
    done_full  = 1'b0;
    done_short = 1'b0;
    done_drop  = 1'b0;
    busy       = 1'b0;
    case (state_q)
      IDLE_S: begin
        busy = 1'b0;
      end
      RECV_S: begin
        busy = 1'b1;
        if (ser_data_val_i) begin
          if (cnt == LAST_CNT) begin
            done_full = 1'b1;
            cnt_clear = 1'b1;
          end
        end else begin
          cnt_clear = 1'b1;
          if (cnt >= MIN_CNT) done_short = 1'b1;
          else                done_drop  = 1'b1;
        end
      end
      default: begin
        cnt_clear = 1'b1;
      end
    endcase
  end

  // A short word of n bits sits in the low n bits; move it to the top.
  assign align_shamt = FULL_CNT - cnt;

  always_comb begin
    data_d = data_q;
    mod_d  = mod_q;
    if (done_full) begin
      data_d = {sr[W-2:0], ser_data_i};
      mod_d  = DATA_MOD_WIDTH'(data_mod_from_count(W, W));
    end else if (done_short) begin
      data_d = sr << align_shamt;
      mod_d  = DATA_MOD_WIDTH'(data_mod_from_count(32'(cnt), W));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      data_q <= '0;
      mod_q  <= '0;
      val_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      data_q <= data_d;
      mod_q  <= mod_d;
      val_q  <= done_full | done_short;
      drop_q <= done_drop;
    end
  end

  assign deser_data_o     = data_q;
  assign deser_data_mod_o = mod_q;
  assign deser_data_val_o = val_q;
  assign drop_o           = drop_q;
  assign busy_o           = busy;

endmodule
